// File: rtl/id_stage_pipe.sv
// Decode stage with regfile, forwarding, load-use stall and branch resolution; ID/EX latency 1 cycle.
// Optional same-cycle write-back bypass on regfile reads: define ID_WB_BYPASS_EN. Backpressure: o_stall holds PC and IF/ID.
module id_stage_pipe #(
   parameter int NB_REG   = 32,
   parameter int NB_ADDR  = 5,
   parameter int NB_FUNCT = 6
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_dunit_clk_en,
   input  logic                i_valid,
   input  logic [NB_REG-1:0]   i_inst,
   input  logic [NB_REG-1:0]   i_pcplus4,
   input  logic                i_wb_we,
   input  logic [NB_ADDR-1:0]  i_wb_addr,
   input  logic [NB_REG-1:0]   i_wb_data,
   input  logic                i_ex_memread,
   input  logic [NB_ADDR-1:0]  i_ex_rt_addr,
   input  logic [NB_REG-1:0]   i_mem_fwd_data,
   input  logic [1:0]          i_fwd_a,
   input  logic [1:0]          i_fwd_b,
   input  logic                i_branch,
   input  logic                i_isBeq,
   input  logic [NB_ADDR-1:0]  i_dunit_addr,
   output logic [NB_REG-1:0]   o_dunit_reg,
   output logic                o_stall,
   output logic                o_pcsrc,
   output logic [NB_REG-1:0]   o_branch_target,
   output logic [NB_REG-1:0]   o_pc_jsel,
   output logic                o_valid,
   output logic [NB_REG-1:0]   o_rs_data,
   output logic [NB_REG-1:0]   o_rt_data,
   output logic [NB_REG-1:0]   o_imm,
   output logic [NB_REG-1:0]   o_pcplus8,
   output logic [NB_FUNCT-1:0] o_funct,
   output logic [NB_ADDR-1:0]  o_rs_addr,
   output logic [NB_ADDR-1:0]  o_rt_addr,
   output logic [NB_ADDR-1:0]  o_rd_addr
);

   typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

   state_t              state_q;
   logic [NB_REG-1:0]   regs_q [2**NB_ADDR];

   logic [NB_ADDR-1:0]  rs, rt, rd;
   logic [NB_REG-1:0]   imm, rs_rf, rt_rf, rs_val, rt_val;
   logic                load_use, bubble, taken;
   logic                unused_opcode;

   assign rs  = i_inst[21 +: NB_ADDR];
   assign rt  = i_inst[16 +: NB_ADDR];
   assign rd  = i_inst[11 +: NB_ADDR];
   assign imm = {{(NB_REG-16){i_inst[15]}}, i_inst[15:0]};
   assign unused_opcode = ^i_inst[NB_REG-1:26];

   function automatic logic [NB_REG-1:0] rf_read(input logic [NB_ADDR-1:0] a,
                                                 input logic [NB_REG-1:0] stored);
      logic [NB_REG-1:0] r;
      r = (a == '0) ? '0 : stored;
`ifdef ID_WB_BYPASS_EN
      if (i_wb_we && a == i_wb_addr && a != '0)
         r = i_wb_data;
`endif
      return r;
   endfunction

   assign rs_rf       = rf_read(rs, regs_q[rs]);
   assign rt_rf       = rf_read(rt, regs_q[rt]);
   assign o_dunit_reg = rf_read(i_dunit_addr, regs_q[i_dunit_addr]);

   always_comb begin
      rs_val = rs_rf;
      rt_val = rt_rf;
      case (i_fwd_a)
         2'b01:   rs_val = i_mem_fwd_data;
         2'b10:   rs_val = i_wb_data;
         default: rs_val = rs_rf;
      endcase
      case (i_fwd_b)
         2'b01:   rt_val = i_mem_fwd_data;
         2'b10:   rt_val = i_wb_data;
         default: rt_val = rt_rf;
      endcase
   end

   assign load_use = i_valid & i_ex_memread & (i_ex_rt_addr != '0) &
                     ((i_ex_rt_addr == rs) | (i_ex_rt_addr == rt));
   // A flushed slot is discarded outright, so it can neither stall nor branch.
   assign o_stall  = load_use & (state_q != S_FLUSH);
   assign taken    = i_branch & i_valid & (state_q != S_FLUSH) & ~load_use &
                     (i_isBeq ? (rs_val == rt_val) : (rs_val != rt_val));
   assign o_pcsrc  = taken;
   assign bubble   = o_stall | (state_q == S_FLUSH);

   assign o_branch_target = i_pcplus4 + (imm << 2);
   assign o_pc_jsel       = rs_val;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= S_RUN;
         o_valid   <= 1'b0;
         o_rs_data <= '0;
         o_rt_data <= '0;
         o_imm     <= '0;
         o_pcplus8 <= '0;
         o_funct   <= '0;
         o_rs_addr <= '0;
         o_rt_addr <= '0;
         o_rd_addr <= '0;
         for (int k = 0; k < 2**NB_ADDR; k++)
            regs_q[k] <= '0;
      end else if (i_dunit_clk_en) begin
         if (i_wb_we && i_wb_addr != '0)
            regs_q[i_wb_addr] <= i_wb_data;

         if (state_q == S_FLUSH)
            state_q <= S_RUN;
         else if (load_use)
            state_q <= S_STALL;
         else if (taken)
            state_q <= S_FLUSH;
         else
            state_q <= S_RUN;

         if (bubble) begin
            o_valid   <= 1'b0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm     <= '0;
            o_pcplus8 <= '0;
            o_funct   <= '0;
            o_rs_addr <= '0;
            o_rt_addr <= '0;
            o_rd_addr <= '0;
         end else begin
            o_valid   <= i_valid;
            o_rs_data <= rs_val;
            o_rt_data <= rt_val;
            o_imm     <= imm;
            o_pcplus8 <= i_pcplus4 + NB_REG'(4);
            o_funct   <= i_inst[NB_FUNCT-1:0];
            o_rs_addr <= rs;
            o_rt_addr <= rt;
            o_rd_addr <= rd;
         end
      end
   end

endmodule
